// File: rtl/l2_port_arbiter_pkg.sv
// Shared LC3-b types for the L2 port arbiter: line/word types, FSM states and requester ids.
package l2_port_arbiter_pkg;

  localparam int unsigned LC3B_ADDR_WIDTH = 16;
  localparam int unsigned LC3B_LINE_WIDTH = 128;

  typedef logic [LC3B_ADDR_WIDTH-1:0] lc3b_word;
  typedef logic [LC3B_LINE_WIDTH-1:0] lc3b_line;

  typedef enum logic [1:0] {
    IDLE,
    SERVE_I,
    SERVE_D
  } l2_arb_state_t;

  typedef enum logic {
    REQ_I,
    REQ_D
  } l2_requester_t;

endpackage

// File: rtl/l2_port_arbiter_sat_counter.sv
// Saturating up-counter with async active-low reset; holds at all-ones.
module sat_counter #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (inc && (count != {WIDTH{1'b1}})) begin
      count <= count + WIDTH'(1);
    end
  end

endmodule

// File: rtl/l2_port_arbiter.sv
// Round-robin arbiter sharing one L2 port between the I-side and D-side L1 miss handlers.
module l2_port_arbiter
  import l2_port_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 16,
  parameter int unsigned LINE_WIDTH = 128,
  parameter int unsigned CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  i_read,
  input  logic [ADDR_WIDTH-1:0] i_address,
  output logic [LINE_WIDTH-1:0] i_rdata,
  output logic                  i_resp,
  input  logic                  d_read,
  input  logic                  d_write,
  input  logic [ADDR_WIDTH-1:0] d_address,
  input  logic [LINE_WIDTH-1:0] d_wdata,
  output logic [LINE_WIDTH-1:0] d_rdata,
  output logic                  d_resp,
  output logic                  l2_read,
  output logic                  l2_write,
  output logic [ADDR_WIDTH-1:0] l2_address,
  output logic [LINE_WIDTH-1:0] l2_wdata,
  input  logic [LINE_WIDTH-1:0] l2_rdata,
  input  logic                  l2_resp,
  output logic [CNT_WIDTH-1:0]  i_grant_cnt,
  output logic [CNT_WIDTH-1:0]  d_grant_cnt
);

  l2_arb_state_t state, next_state;
  l2_requester_t last_grant;
  logic          req_i, req_d;
  logic          grant_i, grant_d;

  assign i_rdata = l2_rdata;
  assign d_rdata = l2_rdata;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Grant decision in IDLE; completion detect and response routing while serving.
  always_comb begin
    next_state = state;
    grant_i    = 1'b0;
    grant_d    = 1'b0;
    i_resp     = 1'b0;
    d_resp     = 1'b0;
    req_i      = i_read;
    req_d      = d_read | d_write;
    unique case (state)
      IDLE: begin
        if (req_i && req_d) begin
          if (last_grant == REQ_I) begin
            grant_d = 1'b1;
          end else begin
            grant_i = 1'b1;
          end
        end else if (req_d) begin
          grant_d = 1'b1;
        end else if (req_i) begin
          grant_i = 1'b1;
        end
        if (grant_d) begin
          next_state = SERVE_D;
        end else if (grant_i) begin
          next_state = SERVE_I;
        end
      end
      SERVE_I: begin
        if (l2_resp) begin
          i_resp     = 1'b1;
          next_state = IDLE;
        end
      end
      SERVE_D: begin
        if (l2_resp) begin
          d_resp     = 1'b1;
          next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // Command register: captured on the granting edge, held until the L2 completes.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      l2_read    <= 1'b0;
      l2_write   <= 1'b0;
      l2_address <= '0;
      l2_wdata   <= '0;
      last_grant <= REQ_I;
    end else if (grant_d) begin
      l2_address <= d_address;
      l2_write   <= d_write;
      l2_read    <= ~d_write;
      if (d_write) begin
        l2_wdata <= d_wdata;
      end
      last_grant <= REQ_D;
    end else if (grant_i) begin
      l2_address <= i_address;
      l2_write   <= 1'b0;
      l2_read    <= 1'b1;
      last_grant <= REQ_I;
    end else if (i_resp || d_resp) begin
      l2_read  <= 1'b0;
      l2_write <= 1'b0;
    end
  end

  sat_counter #(
    .WIDTH(CNT_WIDTH)
  ) u_i_cnt (
    .clk  (clk),
    .rst_n(reset_n),
    .inc  (i_resp),
    .count(i_grant_cnt)
  );

  sat_counter #(
    .WIDTH(CNT_WIDTH)
  ) u_d_cnt (
    .clk  (clk),
    .rst_n(reset_n),
    .inc  (d_resp),
    .count(d_grant_cnt)
  );

endmodule

// File: doc/l2_port_arbiter.md
Name: l2_port_arbiter

Overview:
Shares the single L2 cache port between the instruction-side and data-side L1 miss handlers of the pipelined LC-3b core. Each side issues line-sized read or write-back requests with a level-sensitive read/write plus resp handshake. The arbiter grants one side at a time, registers the winning command onto the L2 port, and routes the L2 response back to the winner. Round-robin on contention; saturating grant counters for performance debug.

Parameters:
ADDR_WIDTH, 16, byte address width (lc3b_word)
LINE_WIDTH, 128, cache line width in bits (lc3b_line)
CNT_WIDTH, 16, width of each saturating grant counter

Ports:
clk  in  1  system clock, rising edge
reset_n  in  1  asynchronous active-low reset
i_read  in  1  I-side line read request, held until i_resp
i_address  in  ADDR_WIDTH  I-side line address
i_rdata  out  LINE_WIDTH  line returned to I-side
i_resp  out  1  one-cycle completion pulse to I-side
d_read  in  1  D-side line read request
d_write  in  1  D-side line write-back request
d_address  in  ADDR_WIDTH  D-side line address
d_wdata  in  LINE_WIDTH  D-side write-back data
d_rdata  out  LINE_WIDTH  line returned to D-side
d_resp  out  1  one-cycle completion pulse to D-side
l2_read  out  1  read command to L2
l2_write  out  1  write command to L2
l2_address  out  ADDR_WIDTH  registered address to L2
l2_wdata  out  LINE_WIDTH  registered write data to L2
l2_rdata  in  LINE_WIDTH  L2 read data, valid with l2_resp
l2_resp  in  1  L2 completion pulse
i_grant_cnt  out  CNT_WIDTH  count of completed I-side transactions, saturating
d_grant_cnt  out  CNT_WIDTH  count of completed D-side transactions, saturating

Behaviour:
- Reset (async, reset_n low): state IDLE; l2_read, l2_write, i_resp, d_resp = 0; l2_address, l2_wdata = 0; last_grant = I (so D wins first contention); both counters = 0. Outputs drop immediately, without waiting for a clk edge.
- States: IDLE, SERVE_I, SERVE_D.
- IDLE: req_i = i_read; req_d = d_read | d_write.
  - Only one side requesting: go to that side's SERVE state.
  - Both requesting: grant the side not equal to last_grant.
  - Neither requesting: stay in IDLE.
  - On the granting edge: latch the address into l2_address. For D writes, latch d_wdata into l2_wdata. Latch op; d_write has priority if d_read and d_write are both high. Set last_grant.
- SERVE_x: l2_read or l2_write asserted from registered op (Moore output). Command, address and data stay stable until l2_resp.
  - On a cycle with l2_resp = 1: x_resp = 1 combinationally in that same cycle; x_rdata = l2_rdata. Next state is IDLE. Increment x_grant_cnt unless it equals all-ones.
- i_rdata and d_rdata are driven from l2_rdata at all times. They are meaningful only with the matching resp.
- Latency: request seen at edge t, so l2_read/l2_write are high in cycle t+1. Minimum occupancy is 2 cycles (1 grant cycle + L2 latency).
- The mandatory IDLE cycle after each resp gives the requester time to drop its request, so a stale request is never re-granted.
- The requester's inputs may change while it is not granted. After grant, changes to them are ignored.
- l2_resp in IDLE is ignored: no resp is forwarded and no counter changes.
- Starvation bound: a waiting side is granted no later than after one transaction of the other side.
- If reset_n is asserted mid-transaction, the in-flight L2 command is abandoned. The requester sees no resp.

Decomposition:
- lc3b_types gains:
  - lc3b_line (LINE_WIDTH logic vector)
  - l2_arb_state_t enum {IDLE, SERVE_I, SERVE_D}
  - l2_requester_t enum {REQ_I, REQ_D}
- One sub-module, sat_counter (width parameter, increment enable, async active-low reset). It is instantiated twice for the grant counters.

Test Plan:
- Reset mid-SERVE_D with l2_write high → l2_write = 0 before the next clk edge. State is IDLE and both counters = 0 after release.
- i_read only, address 0x1230; L2 returns 0xDEAD...BEEF after 3 cycles → l2_read high from cycle 1, l2_address = 0x1230. i_resp pulses for 1 cycle with i_rdata = 0xDEAD...BEEF, i_grant_cnt = 1, then IDLE.
- i_read and d_write both high after reset → D is granted first: l2_write = 1, l2_address/l2_wdata = D values. I is granted immediately after the IDLE cycle. Both counters = 1.
- Continuous d_read and i_read for 6 transactions → grants alternate D, I, D, I, D, I; no side gets two grants in a row.
- d_address changes 0x0040 → 0x0080 during SERVE_D → l2_address stays 0x0040 until l2_resp.
- Spurious l2_resp in IDLE → no i_resp/d_resp and counters unchanged. Force i_grant_cnt to 0xFFFF and complete one I transaction → counter remains 0xFFFF.
